// File: rtl/manchester_frame_deframer.sv
// rtl/manchester_frame_deframer.sv - sync-word hunt, payload assembly and even-parity check of decoded Manchester bits
// Optional statistics counters (frameCount, errCount) are enabled by defining DEFRAME_STATS_EN.
module manchester_frame_deframer #(
  parameter logic [7:0] SYNC_WORD      = 8'hA5,
  parameter int         PAYLOAD_BITS   = 16,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                    osc,
  input  logic                    globalResetN,
  input  logic                    recoveredData,
  input  logic                    balancedCLK,
  output logic [PAYLOAD_BITS-1:0] frameData,
  output logic                    frameValid,
  input  logic                    frameReady,
`ifdef DEFRAME_STATS_EN
  output logic [7:0]              frameCount,
  output logic [7:0]              errCount,
`endif
  output logic                    parityErr,
  output logic                    timeoutErr,
  output logic                    overrun
);

  localparam int BCW = $clog2(PAYLOAD_BITS + 1);
  localparam int ICW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(PAYLOAD_BITS - 1);
  localparam logic [ICW-1:0] IDLE_LIMIT = ICW'(TIMEOUT_CYCLES);
  localparam logic [ICW-1:0] IDLE_LAST  = ICW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, PARITY} stateT;

  stateT                   state;
  logic                    d1, d2, c1, c2, c3;
  logic [7:0]              huntReg;
  logic [PAYLOAD_BITS-1:0] payloadReg;
  logic [BCW-1:0]          bitCount;
  logic [ICW-1:0]          idleCount;

  logic                    strobe, bitIn, parityGood, bufferFree, loadFrame, idleExpire;
  logic [7:0]              huntNext;
  logic [PAYLOAD_BITS:0]   payloadWide;

  always_ff @(posedge osc or negedge globalResetN) begin
    if (!globalResetN) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
      c1 <= 1'b0;
      c2 <= 1'b0;
      c3 <= 1'b0;
    end else begin
      d1 <= recoveredData;
      d2 <= d1;
      c1 <= balancedCLK;
      c2 <= c1;
      c3 <= c2;
    end
  end

  assign strobe      = c2 & ~c3;
  assign bitIn       = d2;
  assign huntNext    = {huntReg[6:0], bitIn};
  // One bit wider than the payload so a single-bit payload still shifts cleanly.
  assign payloadWide = {payloadReg, bitIn};
  assign parityGood  = ~(^payloadWide);
  assign bufferFree  = ~frameValid | frameReady;
  assign loadFrame   = (state == PARITY) & strobe & parityGood & bufferFree;
  assign idleExpire  = (state != HUNT) & ~strobe & (idleCount >= IDLE_LAST);

  always_ff @(posedge osc or negedge globalResetN) begin
    if (!globalResetN) begin
      state      <= HUNT;
      huntReg    <= 8'd0;
      payloadReg <= '0;
      bitCount   <= '0;
      idleCount  <= '0;
      frameData  <= '0;
      frameValid <= 1'b0;
      parityErr  <= 1'b0;
      timeoutErr <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parityErr  <= 1'b0;
      timeoutErr <= 1'b0;
      overrun    <= 1'b0;

      if (frameValid && frameReady) frameValid <= 1'b0;
      if (loadFrame) begin
        frameData  <= payloadReg;
        frameValid <= 1'b1;
      end

      if (state != HUNT && !strobe) begin
        // A strobe always wins over an expiring idle count.
        if (idleExpire) begin
          timeoutErr <= 1'b1;
          huntReg    <= 8'd0;
          idleCount  <= IDLE_LIMIT;
          state      <= HUNT;
        end else begin
          idleCount <= idleCount + ICW'(1);
        end
      end else if (strobe) begin
        case (state)
          HUNT: begin
            huntReg <= huntNext;
            if (huntNext == SYNC_WORD) begin
              state     <= PAYLOAD;
              bitCount  <= '0;
              idleCount <= '0;
            end
          end
          PAYLOAD: begin
            payloadReg <= payloadWide[PAYLOAD_BITS-1:0];
            bitCount   <= bitCount + BCW'(1);
            idleCount  <= '0;
            if (bitCount == LAST_BIT) state <= PARITY;
          end
          PARITY: begin
            if (!parityGood)      parityErr <= 1'b1;
            else if (!bufferFree) overrun   <= 1'b1;
            huntReg   <= 8'd0;
            idleCount <= '0;
            state     <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef DEFRAME_STATS_EN
  always_ff @(posedge osc or negedge globalResetN) begin
    if (!globalResetN) begin
      frameCount <= 8'd0;
      errCount   <= 8'd0;
    end else begin
      if (loadFrame) frameCount <= frameCount + 8'd1;
      if ((parityErr || timeoutErr || overrun) && errCount != 8'hFF) errCount <= errCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_manchester_frame_deframer.sv
// tb/tb_manchester_frame_deframer.sv - directed scoreboard bench for manchester_frame_deframer
module tb_manchester_frame_deframer;

  logic        osc = 1'b0;
  logic        globalResetN, recoveredData, balancedCLK, frameReady;
  logic [15:0] frameData;
  logic        frameValid, parityErr, timeoutErr, overrun;
`ifdef DEFRAME_STATS_EN
  logic [7:0]  frameCount, errCount;
`endif

  int vectors = 0;
  int miscompares = 0;
  int xferCnt = 0, validCycles = 0, parityCnt = 0, timeoutCnt = 0, overrunCnt = 0;
  int loadsSinceReset = 0;
  logic [15:0] expQ[$];

  manchester_frame_deframer dut (
    .osc(osc),
    .globalResetN(globalResetN),
    .recoveredData(recoveredData),
    .balancedCLK(balancedCLK),
    .frameData(frameData),
    .frameValid(frameValid),
    .frameReady(frameReady),
`ifdef DEFRAME_STATS_EN
    .frameCount(frameCount),
    .errCount(errCount),
`endif
    .parityErr(parityErr),
    .timeoutErr(timeoutErr),
    .overrun(overrun)
  );

  always #5 osc = ~osc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: a transfer happens on the next edge whenever valid and ready are both high.
  always @(negedge osc) begin
    #1;
    if (frameValid === 1'b1) validCycles++;
    if (parityErr === 1'b1) parityCnt++;
    if (timeoutErr === 1'b1) timeoutCnt++;
    if (overrun === 1'b1) overrunCnt++;
    if (frameValid === 1'b1 && frameReady === 1'b1) begin
      xferCnt++;
      if (expQ.size() == 0) check("unexpected frame", 32'(frameData), 32'hFFFF_FFFF);
      else check("frameData scoreboard", 32'(frameData), 32'(expQ.pop_front()));
    end
  end

  task automatic sendBit(input logic b);
    recoveredData = b;
    balancedCLK = 1'b1;
    repeat (3) @(negedge osc);
    balancedCLK = 1'b0;
    repeat (3) @(negedge osc);
  endtask

  task automatic sendBits(input logic [31:0] v, input int n);
    logic [31:0] w;
    w = v;
    for (int i = n - 1; i >= 0; i--) sendBit(w[i]);
  endtask

  task automatic sendFrame(input logic [15:0] payload, input logic par, input bit expectLoad);
    if (expectLoad) begin
      expQ.push_back(payload);
      loadsSinceReset++;
    end
    sendBits(32'hA5, 8);
    sendBits(32'(payload), 16);
    sendBit(par);
    repeat (4) @(negedge osc);
  endtask

  int x0, v0, p0, t0, o0, n;
  bit seen;

  initial begin
    globalResetN = 1'b0;
    recoveredData = 1'b0;
    balancedCLK = 1'b0;
    frameReady = 1'b1;
    repeat (3) @(negedge osc);
    check("reset frameValid", 32'(frameValid), 32'd0);
    check("reset frameData", 32'(frameData), 32'd0);
    check("reset errs", {29'd0, parityErr, timeoutErr, overrun}, 32'd0);
    globalResetN = 1'b1;
    repeat (2) @(negedge osc);

    // Basic frame with latency check on the parity bit.
    x0 = xferCnt; v0 = validCycles; p0 = parityCnt; t0 = timeoutCnt; o0 = overrunCnt;
    expQ.push_back(16'h3C5A);
    loadsSinceReset++;
    sendBits(32'hA5, 8);
    sendBits(32'h3C5A, 16);
    recoveredData = 1'b0;
    balancedCLK = 1'b1;
    @(negedge osc);
    check("latency edge1 valid", 32'(frameValid), 32'd0);
    @(negedge osc);
    check("latency edge2 valid", 32'(frameValid), 32'd0);
    @(negedge osc);
    check("latency edge3 valid", 32'(frameValid), 32'd1);
    check("basic frameData", 32'(frameData), 32'h3C5A);
    balancedCLK = 1'b0;
    @(negedge osc);
    check("basic valid dropped", 32'(frameValid), 32'd0);
    repeat (6) @(negedge osc);
    check("basic xfers", 32'(xferCnt - x0), 32'd1);
    check("basic valid cycles", 32'(validCycles - v0), 32'd1);
    check("basic err pulses", 32'((parityCnt - p0) + (timeoutCnt - t0) + (overrunCnt - o0)), 32'd0);

    // Parity error, then re-lock.
    x0 = xferCnt; v0 = validCycles; p0 = parityCnt;
    sendFrame(16'h3C5A, 1'b1, 1'b0);
    check("parityErr pulses", 32'(parityCnt - p0), 32'd1);
    check("parity no valid", 32'(validCycles - v0), 32'd0);
    sendFrame(16'h0001, 1'b1, 1'b1);
    check("relock xfers", 32'(xferCnt - x0), 32'd1);
    check("relock parity pulses", 32'(parityCnt - p0), 32'd1);

    // Overrun with consumer stalled.
    o0 = overrunCnt;
    frameReady = 1'b0;
    sendFrame(16'h1111, 1'b0, 1'b1);
    sendFrame(16'h2222, 1'b0, 1'b0);
    check("overrun pulses", 32'(overrunCnt - o0), 32'd1);
    check("overrun frameValid", 32'(frameValid), 32'd1);
    check("overrun frameData kept", 32'(frameData), 32'h1111);
    frameReady = 1'b1;
    @(negedge osc);
    @(negedge osc);
    check("overrun valid drops", 32'(frameValid), 32'd0);

    // Timeout after 5 payload bits.
    t0 = timeoutCnt; x0 = xferCnt;
    sendBits(32'hA5, 8);
    sendBits(32'hA, 4);
    recoveredData = 1'b1;
    balancedCLK = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge osc);
      n++;
      if (n == 3) balancedCLK = 1'b0;
      if (timeoutErr === 1'b1) seen = 1'b1;
    end
    check("timeout latency", 32'(n), 32'd258);
    repeat (4) @(negedge osc);
    check("timeout pulses", 32'(timeoutCnt - t0), 32'd1);
    sendFrame(16'hBEEF, 1'b1, 1'b1);
    check("post-timeout xfers", 32'(xferCnt - x0), 32'd1);
    check("post-timeout frameData", 32'(frameData), 32'hBEEF);

    // Embedded sync word, then reset mid-frame.
    x0 = xferCnt; p0 = parityCnt;
    sendFrame(16'h00A5, 1'b0, 1'b1);
    check("embedded sync xfers", 32'(xferCnt - x0), 32'd1);
    check("embedded sync parity", 32'(parityCnt - p0), 32'd0);
    check("embedded sync frameData", 32'(frameData), 32'h00A5);
    sendBits(32'hA5, 8);
    sendBits(32'h5A, 8);
    globalResetN = 1'b0;
    loadsSinceReset = 0;
    repeat (2) @(negedge osc);
    check("midreset frameValid", 32'(frameValid), 32'd0);
    check("midreset frameData", 32'(frameData), 32'd0);
    check("midreset errs", {29'd0, parityErr, timeoutErr, overrun}, 32'd0);
    globalResetN = 1'b1;
    repeat (2) @(negedge osc);
    x0 = xferCnt;
    sendFrame(16'h3C5A, 1'b0, 1'b1);
    check("after reset xfers", 32'(xferCnt - x0), 32'd1);

    // Accept and load in the same cycle.
    o0 = overrunCnt;
    frameReady = 1'b0;
    sendFrame(16'h1111, 1'b0, 1'b1);
    expQ.push_back(16'h2222);
    loadsSinceReset++;
    sendBits(32'hA5, 8);
    sendBits(32'h2222, 16);
    recoveredData = 1'b0;
    balancedCLK = 1'b1;
    @(negedge osc);
    @(negedge osc);
    frameReady = 1'b1;
    @(negedge osc);
    frameReady = 1'b0;
    check("simul frameValid", 32'(frameValid), 32'd1);
    check("simul frameData", 32'(frameData), 32'h2222);
    balancedCLK = 1'b0;
    repeat (4) @(negedge osc);
    check("simul no overrun", 32'(overrunCnt - o0), 32'd0);
    check("simul valid held", 32'(frameValid), 32'd1);
`ifdef DEFRAME_STATS_EN
    check("frameCount", 32'(frameCount), 32'(loadsSinceReset));
    check("errCount", 32'(errCount), 32'd0);
`endif
    frameReady = 1'b1;
    repeat (3) @(negedge osc);
    check("final valid low", 32'(frameValid), 32'd0);
    check("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
